multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Moore-style sequencer for the multicycle variant of the MIPS datapath. One shared memory, one ALU and explicit IR/PC write enables are stepped through fetch, decode, execute, memory and writeback states. It consumes the IR opcode and drives every datapath enable and mux select. A status port reports the current state and a sticky illegal-opcode flag.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_J, 6'b000010, jump opcode

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset (0 = reset)
opcode  input  6  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory done handshake; used only with MEM_WAIT_EN, ignored otherwise
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load qualified by ALU zero
i_or_d  output  1  memory address select (0 = PC, 1 = ALUOut)
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register load
mem_to_reg  output  1  writeback select (1 = MDR)
reg_dst  output  1  destination select (1 = rd)
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A select (0 = PC, 1 = A reg)
alu_src_b  output  2  ALU B select (00 = B reg, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2)
alu_op  output  2  to ALU control (00 = add, 01 = sub, 10 = funct)
pc_source  output  2  next PC select (00 = ALU, 01 = ALUOut, 10 = jump target)
state  output  4  current state encoding
illegal_op  output  1  sticky unknown-opcode flag

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Codes 12-15 are unreachable; if entered, the next state is FETCH.
- Reset (reset=0): state forced to FETCH asynchronously.
- While reset=0, all control outputs are forced to 0 combinationally, illegal_op=0 and state=0.
- The first FETCH cycle is the first clk edge after reset rises.
- Transitions:
  - FETCH->DECODE.
  - DECODE branches on opcode: LW/SW->MEMADR, RTYPE->EXECUTE, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP.
  - DECODE with any other opcode -> FETCH, and sets illegal_op (sticky until reset).
  - MEMADR: LW->MEMRD, SW->MEMWR.
  - MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP all -> FETCH.
- Outputs are decoded from state only. Unlisted signals are 0.
  - FETCH: mem_read=1, i_or_d=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, pc_write=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - MEMADR, ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: mem_read=1, i_or_d=1.
  - MEMWB: mem_to_reg=1, reg_dst=0, reg_write=1.
  - MEMWR: mem_write=1, i_or_d=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
  - JUMP: pc_source=10, pc_write=1.
- Cycles per instruction (single-cycle memory): R-type 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3, illegal 2.
- mem_read and mem_write are never asserted in the same cycle.
- reg_write is asserted for exactly one cycle per writing instruction.
- Reset mid-instruction: an in-flight write is abandoned and the FSM restarts at FETCH.

Optional Feature:
MEM_WAIT_EN
- Defined: FETCH, MEMRD and MEMWR hold their state while mem_ready=0.
  - mem_read/mem_write and i_or_d stay asserted for the whole hold.
  - In FETCH, ir_write and pc_write are asserted only in the cycle with mem_ready=1 (Mealy gating), so the PC advances exactly once per fetch.
  - The next-state transition happens only on mem_ready=1.
- Undefined: mem_ready is unconnected internally, and behaviour and CPI are as listed above.

Test Plan:
- Release reset, opcode=OP_RTYPE -> state sequence 0,1,6,7,0. reg_write=1 only in state 7, with reg_dst=1. pc_write=1 only in state 0.
- opcode=OP_LW -> states 0,1,2,3,4,0. mem_read=1 with i_or_d=1 in state 3. mem_to_reg=1 and reg_write=1 in state 4.
- opcode=OP_SW then OP_BEQ -> SW: 0,1,2,5,0, with mem_write=1 only in state 5. BEQ: 0,1,8,0, with pc_write_cond=1, alu_op=01 and pc_source=01 in state 8.
- opcode=6'b111111 in DECODE -> next state 0 and illegal_op=1. illegal_op stays 1 through a following OP_J (states 0,1,11,0) until reset pulses low.
- Assert reset=0 asynchronously mid-MEMRD -> state=0 immediately and all control outputs 0 before the next clk edge. After release, FETCH resumes.
- With MEM_WAIT_EN defined: hold mem_ready=0 for 3 cycles in FETCH -> state stays 0 and mem_read=1 throughout. pc_write and ir_write assert only on the mem_ready=1 cycle, then state goes to 1.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer (master) and the MIPS datapath (slave).
// Carries the IR opcode, the memory handshake, every datapath enable/select and status.
interface multicycle_control_fsm_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multicycle MIPS datapath with a sticky illegal-opcode flag.
// Optional MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall on mem_ready=0.
module multicycle_control_fsm (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_fsm_if.master  bus
);
    localparam int unsigned OP_W  = 6;
    localparam int unsigned ST_W  = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [ST_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   illegal_q;
    logic   illegal_d;
    logic   mem_ready_c;

`ifdef MEM_WAIT_EN
    assign mem_ready_c = bus.mem_ready;
`else
    assign mem_ready_c = 1'b1;
`endif

    // State and sticky flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            FETCH:   if (mem_ready_c) state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (bus.opcode == OP_LW)      state_d = MEMRD;
                else if (bus.opcode == OP_SW) state_d = MEMWR;
                else                          state_d = FETCH;
            end
            MEMRD:   if (mem_ready_c) state_d = MEMWB;
            MEMWR:   if (mem_ready_c) state_d = FETCH;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Control decode from state; reset blanks every control combinationally
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        case (state_q)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.ir_write  = mem_ready_c;
                bus.pc_write  = mem_ready_c;
                bus.alu_src_b = 2'b01;
            end
            DECODE:  bus.alu_src_b = 2'b11;
            MEMADR, ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
            end
            MEMWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            EXECUTE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            ALUWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_source     = 2'b01;
                bus.pc_write_cond = 1'b1;
            end
            ADDIWB:  bus.reg_write = 1'b1;
            JUMP: begin
                bus.pc_source = 2'b10;
                bus.pc_write  = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.i_or_d        = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.ir_write      = 1'b0;
            bus.mem_to_reg    = 1'b0;
            bus.reg_dst       = 1'b0;
            bus.reg_write     = 1'b0;
            bus.alu_src_a     = 1'b0;
            bus.alu_src_b     = 2'b00;
            bus.alu_op        = 2'b00;
            bus.pc_source     = 2'b00;
        end
    end

    assign bus.state      = state_q;
    assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench for multicycle_control_fsm against a per-opcode
// state-sequence model and a per-state control table (MEM_WAIT_EN stall test when defined).
module tb_multicycle_control_fsm;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic model_ill = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Expected control vector for a state, straight from the control table
    function automatic logic [15:0] exp_ctrl(input int st, input logic ready);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa} = 10'b0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin mr = 1'b1; irw = ready; pw = ready; asb = 2'b01; end
            1:  asb = 2'b11;
            2, 9: begin asa = 1'b1; asb = 2'b10; end
            3:  begin mr = 1'b1; iod = 1'b1; end
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin mw = 1'b1; iod = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pwc = 1'b1; end
            10: rw = 1'b1;
            11: begin psrc = 2'b10; pw = 1'b1; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
    endfunction

    function automatic logic [15:0] obs_ctrl();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int st, input logic ready);
        check({tag, ".state"}, 32'(bus.state), 32'(st));
        check({tag, ".ctrl"}, 32'(obs_ctrl()), 32'(exp_ctrl(st, ready)));
        check({tag, ".illegal"}, 32'(bus.illegal_op), 32'(model_ill));
        check({tag, ".rd_wr_excl"}, 32'(bus.mem_read & bus.mem_write), 32'd0);
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

    // Expected path of one instruction beginning at FETCH
    task automatic path_of(input logic [5:0] op, output int seq[6], output int n);
        seq = '{0, 1, 0, 0, 0, 0};
        case (op)
            OP_RTYPE: begin seq[2] = 6; seq[3] = 7; n = 4; end
            OP_LW:    begin seq[2] = 2; seq[3] = 3; seq[4] = 4; n = 5; end
            OP_SW:    begin seq[2] = 2; seq[3] = 5; n = 4; end
            OP_BEQ:   begin seq[2] = 8; n = 3; end
            OP_ADDI:  begin seq[2] = 9; seq[3] = 10; n = 4; end
            OP_J:     begin seq[2] = 11; n = 3; end
            default:  n = 2;
        endcase
    endtask

    // Apply one instruction (caller is sitting in FETCH) and check every cycle
    task automatic run_instr(input logic [5:0] op, input string tag);
        int seq[6];
        int n;
        int wr_cycles;
        path_of(op, seq, n);
        bus.opcode = op;
        wr_cycles = 0;
        for (int k = 0; k < n; k++) begin
            check_all(tag, seq[k], 1'b1);
            wr_cycles += int'(bus.reg_write);
            if (seq[k] == 1 && !is_legal(op)) model_ill = 1'b1;
            @(posedge clk); #1;
        end
        check({tag, ".reg_write_count"}, 32'(wr_cycles),
              32'((op inside {OP_RTYPE, OP_LW, OP_ADDI}) ? 1 : 0));
    endtask

    initial begin
        logic [5:0] op;
        bus.opcode    = OP_RTYPE;
        bus.mem_ready = 1'b1;

        // Reset state
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.state", 32'(bus.state), 32'd0);
        check("reset.ctrl", 32'(obs_ctrl()), 32'd0);
        check("reset.illegal", 32'(bus.illegal_op), 32'd0);
        reset = 1'b1;
        #1;

        // Directed instructions
        run_instr(OP_RTYPE, "rtype");
        run_instr(OP_LW, "lw");
        run_instr(OP_SW, "sw");
        run_instr(OP_BEQ, "beq");
        run_instr(6'b111111, "illegal");
        run_instr(OP_J, "j_after_illegal");
        run_instr(OP_ADDI, "addi");

        // Asynchronous reset in the middle of MEMRD
        bus.opcode = OP_LW;
        check_all("mid_rst.fetch", 0, 1'b1);
        @(posedge clk); #1;
        check_all("mid_rst.decode", 1, 1'b1);
        @(posedge clk); #1;
        check_all("mid_rst.memadr", 2, 1'b1);
        @(posedge clk); #1;
        check_all("mid_rst.memrd", 3, 1'b1);
        #2 reset = 1'b0;
        #1;
        model_ill = 1'b0;
        check("mid_rst.async_state", 32'(bus.state), 32'd0);
        check("mid_rst.async_ctrl", 32'(obs_ctrl()), 32'd0);
        check("mid_rst.async_illegal", 32'(bus.illegal_op), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        run_instr(OP_LW, "after_rst_lw");

`ifdef MEM_WAIT_EN
        // FETCH stalls while memory is not ready
        bus.opcode    = OP_J;
        bus.mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_all("wait.hold", 0, 1'b0);
            @(posedge clk); #1;
        end
        bus.mem_ready = 1'b1;
        #1;
        check_all("wait.release", 0, 1'b1);
        @(posedge clk); #1;
        check_all("wait.decode", 1, 1'b1);
        @(posedge clk); #1;
        check_all("wait.jump", 11, 1'b1);
        @(posedge clk); #1;
`endif

        // Randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: op = OP_RTYPE;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_ADDI;
                5: op = OP_J;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    if (is_legal(op)) op = 6'b111110;
                end
            endcase
            run_instr(op, $sformatf("rand%0d_op%02h", i, op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
